piso_serializer: RTL and testbench

- Parallel-in, serial-out shift register; the transmit end of the serial bit stream consumed by the variable-tap serial-in shift register.
- Accepts a word plus a bit count over a valid/ready handshake and emits the selected bits MSB-first, one bit per clock-enabled cycle.
- Output polarity and ordering are chosen so that a serial-in register shifting {data, SI} reconstructs the word in its original bit order.
- Supports back-to-back words with no idle bubble.

---
 rtl/piso_serializer_if.sv | 63 ++++++
 rtl/piso_serializer.sv | 106 ++++++++++
 tb/tb_piso_serializer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
// Bundles the parallel-load handshake, the shift enable and the serial
// output side of piso_serializer.
//
// Signals:
//   in_valid  source -> serializer : parallel word offered
//   in_ready  serializer -> source : word accepted at the next rising edge
//   in_data   source -> serializer : parallel word (DW bits)
//   in_len    source -> serializer : number of bits to send minus 1
//   CE        source -> serializer : shift enable, one bit per CE-high cycle
//   SO        serializer -> sink   : serial data, MSB of the selected field first
//   SO_valid  serializer -> sink   : SO carries a valid bit this cycle
//   busy      serializer -> sink   : word in flight
//   done      serializer -> sink   : one-cycle pulse after the last bit of a word
//   dbg_state serializer -> debug  : current FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high. The source keeps in_data/in_len stable while in_valid is
// high and in_ready is low; in_ready may depend combinationally on CE and
// on the current state, but never on in_valid.
// ---------------------------------------------------------------------------
interface piso_serializer_if #(
    parameter int DW   = 32,
    parameter int LENW = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [LENW-1:0] in_len;
    logic            CE;
    logic            SO;
    logic            SO_valid;
    logic            busy;
    logic            done;
    logic            dbg_state;

    modport master (
        output in_valid,
        output in_data,
        output in_len,
        output CE,
        input  in_ready,
        input  SO,
        input  SO_valid,
        input  busy,
        input  done,
        input  dbg_state
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_len,
        input  CE,
        output in_ready,
        output SO,
        output SO_valid,
        output busy,
        output done,
        output dbg_state
    );
endinterface

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in, serial-out shift register. A word plus a bit count is loaded
// over a valid/ready handshake; bits in_data[in_len:0] are then emitted
// MSB-first on SO, one bit per CE-high cycle. A serial-in register that
// shifts {data, SI} on the same CE edges rebuilds the word in its original
// bit order. A new word can be loaded in the last-bit cycle so consecutive
// words stream with no idle bubble.
//
// Ports:
//   CLK   input : clock, all logic on the rising edge
//   RSTN  input : synchronous active-low reset
//   bus   slave : handshake, shift enable and serial outputs (piso_serializer_if)
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int DW   = 32,
    parameter int LENW = 5
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    piso_serializer_if.slave     bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_shreg;
    logic [DW-1:0]   w_shreg_nxt;
    logic [LENW-1:0] r_cnt;
    logic [LENW-1:0] w_cnt_nxt;
    logic            r_done;

    logic            w_last;
    logic            w_ready;
    logic            w_load;
    logic [LENW-1:0] w_shamt;

    // Next-state and datapath logic.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;

        // Left-align the selected field so in_data[in_len] lands on the MSB.
        w_shamt = LENW'(DW - 1) - bus.in_len;

        // Last bit is being consumed this cycle; a new word may load now.
        w_last  = (r_state == ST_SHIFT) && bus.CE && (r_cnt == '0);
        w_ready = RSTN && ((r_state == ST_IDLE) || w_last);
        w_load  = bus.in_valid && w_ready;

        case (r_state)
            ST_IDLE: begin
                // CE has no effect while idle.
            end
            ST_SHIFT: begin
                if (bus.CE) begin
                    if (r_cnt != '0) begin
                        w_shreg_nxt = r_shreg << 1;
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A load overrides the end-of-word return to IDLE (back-to-back).
        if (w_load) begin
            w_state_nxt = ST_SHIFT;
            w_shreg_nxt = bus.in_data << w_shamt;
            w_cnt_nxt   = bus.in_len;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_last;
        end
    end

    // Outputs are forced quiet while reset is held, even in the cycle before
    // the reset edge takes effect on the registers.
    assign bus.in_ready  = w_ready;
    assign bus.SO        = (RSTN && (r_state == ST_SHIFT)) ? r_shreg[DW-1] : 1'b0;
    assign bus.SO_valid  = RSTN && (r_state == ST_SHIFT);
    assign bus.busy      = RSTN && (r_state == ST_SHIFT);
    assign bus.done      = RSTN && r_done;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
// Self-checking bench for piso_serializer (DW=32, LENW=5). The reference
// model is a queue of bits still to be sent for the word in flight; every
// cycle the expected SO/SO_valid/in_ready/busy/done are derived from that
// queue, and each completed word is compared against a capture register
// built from the DUT's SO on CE-high cycles.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int DW   = 32;
    localparam int LENW = 5;

    logic clk;
    logic rstn;

    piso_serializer_if #(.DW(DW), .LENW(LENW)) bus ();

    piso_serializer #(.DW(DW), .LENW(LENW)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int              n_checks = 0;
    int              n_fail   = 0;
    bit              m_q[$];      // bits of the current word not yet consumed
    bit              m_done = 1'b0;
    logic [DW-1:0]   m_word = '0; // selected field of the current word
    logic [DW-1:0]   cap    = '0; // serial-in capture of the DUT's SO

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // advance the model across the rising edge.
    task automatic cyc(input bit r, input bit v, input logic [DW-1:0] d,
                       input logic [LENW-1:0] l, input bit ce, output bit acc);
        bit e_busy, e_so, e_last, e_ready, e_done, so_obs;
        rstn         = r;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_len   = l;
        bus.CE       = ce;
        #1;
        assert (int'(l) < DW) else $error("illegal in_len %0d", l);

        e_busy  = r && (m_q.size() > 0);
        e_so    = e_busy ? m_q[0] : 1'b0;
        e_last  = e_busy && ce && (m_q.size() == 1);
        e_ready = r && (!e_busy || e_last);
        e_done  = r && m_done;
        acc     = v && e_ready;

        chk("SO",       DW'(bus.SO),       DW'(e_so));
        chk("SO_valid", DW'(bus.SO_valid), DW'(e_busy));
        chk("in_ready", DW'(bus.in_ready), DW'(e_ready));
        chk("busy",     DW'(bus.busy),     DW'(e_busy));
        chk("done",     DW'(bus.done),     DW'(e_done));
        so_obs = bus.SO;

        @(posedge clk);
        if (!r) begin
            m_q.delete();
            m_done = 1'b0;
        end else begin
            m_done = e_last;
            if (e_busy && ce) begin
                void'(m_q.pop_front());
                cap = {cap[DW-2:0], so_obs};
                if (m_q.size() == 0) chk("capture", cap, m_word);
            end
            if (acc) begin
                for (int i = int'(l); i >= 0; i--) m_q.push_back(d[i]);
                m_word = d & ({DW{1'b1}} >> (DW - 1 - int'(l)));
                cap    = '0;
            end
        end
        @(negedge clk);
    endtask

    function automatic bit pick_ce(input int mode);
        if (mode == 0) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // Offer a word until accepted, run it out, then one more cycle so the
    // done pulse is checked.
    task automatic send(input logic [DW-1:0] d, input logic [LENW-1:0] l, input int ce_mode);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            cyc(1'b1, 1'b1, d, l, pick_ce(ce_mode), acc);
            n++;
        end
        chk("accepted", DW'(acc), DW'(1));
        n = 0;
        while (m_q.size() != 0 && n < 1000) begin
            cyc(1'b1, 1'b0, '0, '0, pick_ce(ce_mode), acc);
            n++;
        end
        chk("drained", DW'(m_q.size() == 0), DW'(1));
        cyc(1'b1, 1'b0, '0, '0, pick_ce(ce_mode), acc);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit acc;
        bit have;
        logic [DW-1:0]   wd;
        logic [LENW-1:0] wl;
        int ce_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

        rstn         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_len   = '0;
        bus.CE       = 1'b0;
        @(negedge clk);

        // Reset: outputs quiet while held.
        cyc(1'b0, 1'b0, '0, '0, 1'b0, acc);
        cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b1, acc);

        // Idle with CE high: nothing happens.
        cyc(1'b1, 1'b0, '0, '0, 1'b1, acc);

        // Full 32-bit word, CE always high.
        send(32'hA5A5_0F0F, 5'd31, 0);

        // 4-bit field of 0xFFFF_FFF6: upper ones never appear.
        send(32'hFFFF_FFF6, 5'd3, 0);

        // Same word with CE gaps; in_ready low except on the last bit.
        cyc(1'b1, 1'b1, 32'hFFFF_FFF6, 5'd3, 1'b1, acc);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, '0, '0, ce_pat[i][0], acc);
        cyc(1'b1, 1'b0, '0, '0, 1'b1, acc);

        // Back-to-back: 8-bit 0x81 then 1-bit 0x1 held valid.
        cyc(1'b1, 1'b1, 32'h0000_0081, 5'd7, 1'b1, acc);
        for (int i = 0; i < 20 && !(acc && m_q.size() == 1); i++)
            cyc(1'b1, 1'b1, 32'h0000_0001, 5'd0, 1'b1, acc);
        chk("b2b_accept", DW'(acc), DW'(1));
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, '0, '0, 1'b1, acc);

        // Reset after 5 of 16 bits: aborted, no done, then a fresh word.
        cyc(1'b1, 1'b1, 32'h0000_C3A5, 5'd15, 1'b1, acc);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0, '0, 1'b1, acc);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, acc);
        cyc(1'b1, 1'b0, '0, '0, 1'b1, acc);
        send(32'h0000_5A3C, 5'd15, 0);

        // Single bit of value 0.
        send(32'h0000_0000, 5'd0, 0);

        // Random words, lengths, CE and offer timing (including back-to-back).
        have = 1'b0;
        wd   = '0;
        wl   = '0;
        for (int c = 0; c < 2000; c++) begin
            if (!have && $urandom_range(0, 2) != 0) begin
                wd   = $urandom;
                wl   = LENW'($urandom_range(0, DW - 1));
                have = 1'b1;
            end
            cyc(1'b1, have, wd, wl, pick_ce(1), acc);
            if (acc) have = 1'b0;
        end
        for (int i = 0; i < 500 && m_q.size() != 0; i++) cyc(1'b1, 1'b0, '0, '0, 1'b1, acc);
        chk("random_drained", DW'(m_q.size() == 0), DW'(1));
        cyc(1'b1, 1'b0, '0, '0, 1'b1, acc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
